// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath widths, the reset vector, the
// fetch-stage state encoding and the fetch-buffer entry layout.
package mips_pkg;

  localparam int PC_W    = 30;  // word-address width
  localparam int INSTR_W = 32;

  // Word address 0x0010_0000 == byte address 0x0040_0000.
  localparam logic [PC_W-1:0] RESET_PC_DEF = 30'h0010_0000;

  // Encoding 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DROP = 2'b10
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small FIFO of {PC, instr} entries between fetch and decode.
// Entry 0 is always the head; a pop shifts the rest down one slot.
// Push, pop and flush all resolve in one cycle; flush wins over both.
module fetch_buf
  import mips_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  localparam int             CW       = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic          pop_eff;
  logic          push_eff;
  logic [CW-1:0] wr_idx;

  assign pop_eff  = pop && (count != '0);
  assign wr_idx   = count - CW'(pop_eff);
  assign push_eff = push && (wr_idx != CW'(DEPTH));
  assign head     = mem[0];

  // Storage and occupancy update: shift on pop, then write the tail slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      // NOTE: storage is reset here because the head entry drives o_PC/o_instr
      // directly, and those outputs have defined reset values.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{pc: RESET_PC, instr: '0};
      end
    end else if (flush) begin
      count <= '0;
    end else begin
      if (pop_eff) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem[i] <= mem[i+1];
        end
      end
      // A write to the same slot as a shift lands later and takes effect.
      if (push_eff) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_idx == CW'(i)) mem[i] <= push_data;
        end
      end
      count <= count - CW'(pop_eff) + CW'(push_eff);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding word request
// at a time to instruction memory, buffers returned words toward decode and
// applies redirects from next-PC logic.
// Build option: define IFETCH_BUF2_EN for a 2-entry buffer (no bubble on a
// one-cycle decode stall); otherwise a single holding register is used.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_PCSrc,
  input  logic [PC_W-1:0]    i_PCTarget,
  output logic               o_imem_req,
  output logic [PC_W-1:0]    o_imem_addr,
  input  logic               i_imem_ack,
  input  logic [INSTR_W-1:0] i_imem_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_PC,
  output logic [PC_W-1:0]    o_PCPlus1
);

`ifdef IFETCH_BUF2_EN
  localparam int BUF_DEPTH = 2;
`else
  localparam int BUF_DEPTH = 1;
`endif
  localparam int CW = $clog2(BUF_DEPTH + 1);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] fpc_q, fpc_d;   // next fetch address
  logic [PC_W-1:0] rqa_q, rqa_d;   // outstanding request address

  fetch_entry_t    head;
  logic [CW-1:0]   count;
  logic [CW-1:0]   cnt_after_pop;
  logic            pop;
  logic            push;
  logic            space;

  assign pop           = o_valid && i_ready;
  assign cnt_after_pop = count - CW'(pop);
  // Room left after this cycle's pop and a push of the acked word.
  assign space         = (cnt_after_pop + CW'(1)) < CW'(BUF_DEPTH);

  fetch_buf #(
    .DEPTH    (BUF_DEPTH),
    .RESET_PC (RESET_PC)
  ) u_buf (
    .clk       (i_clk),
    .rst       (i_rst),
    .flush     (i_PCSrc),
    .push      (push),
    .push_data ('{pc: rqa_q, instr: i_imem_data}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // Request sequencing: next state, fetch/request addresses and buffer push.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    fpc_d   = fpc_q;
    rqa_d   = rqa_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_PCSrc) begin
          fpc_d = i_PCTarget;
        end else if (cnt_after_pop < CW'(BUF_DEPTH)) begin
          rqa_d   = fpc_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_PCSrc) begin
          // Data acked alongside a redirect is simply not pushed.
          fpc_d   = i_PCTarget;
          state_d = i_imem_ack ? IDLE : DROP;
        end else if (i_imem_ack) begin
          push  = 1'b1;
          fpc_d = rqa_q + 1'b1;
          if (space) rqa_d = rqa_q + 1'b1;
          else       state_d = IDLE;
        end
      end
      DROP: begin
        // Stale request stays on the bus untouched until memory acks it.
        if (i_PCSrc)    fpc_d   = i_PCTarget;
        if (i_imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and address registers; reset abandons any outstanding request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      fpc_q   <= RESET_PC;
      rqa_q   <= RESET_PC;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      fpc_q   <= fpc_d;
      rqa_q   <= rqa_d;
    end
  end

  assign o_imem_req  = (state_q == WAIT) || (state_q == DROP);
  assign o_imem_addr = rqa_q;
  assign o_valid     = (count != '0);
  assign o_instr     = head.instr;
  assign o_PC        = head.pc;
  assign o_PCPlus1   = head.pc + 1'b1;

endmodule
